// File: rtl/risc_toy_pkg.sv
// Shared definitions for the RISC_TOY memory arbiter: default widths,
// requester source encoding and the arbiter state type.
package risc_toy_pkg;

  localparam int DEF_ADDR_W = 30;
  localparam int DEF_DATA_W = 32;

  // Source tag carried alongside each in-flight read.
  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  // D_PRIO: data wins ties. I_FORCE: fetch wins ties after a long data burst.
  typedef enum logic {
    D_PRIO  = 1'b0,
    I_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/risc_toy_rtag_pipe.sv
// In-order read tag delay line. Each stage holds {valid, src}. The depth
// matches the memory read latency, so the last stage lines up with M_RDATA.
module risc_toy_rtag_pipe
  import risc_toy_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic push_valid,
  input  logic push_src,
  output logic out_valid,
  output logic out_src
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] src_q, src_d;

  // Shift every cycle: stage 0 takes the new tag, each later stage its predecessor.
  always_comb begin
    valid_d    = '0;
    src_d      = '0;
    valid_d[0] = push_valid;
    src_d[0]   = push_valid ? push_src : SRC_I;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      src_d[i]   = src_q[i-1];
    end
  end

  // Synchronous clear drops every in-flight tag so no response is ever issued for it.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= '0;
      src_q   <= '0;
    end else begin
      valid_q <= valid_d;
      src_q   <= src_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_src   = src_q[DEPTH-1];

endmodule

// File: rtl/risc_toy_mem_arbiter.sv
// Arbitrates one single-port memory between the fetch and data ports.
// Data has priority, limited by a burst counter that forces a fetch grant
// after D_MAX_BURST consecutive data grants while a fetch is pending.
// Read data is steered back through a tag pipe matched to RD_LAT.
module risc_toy_mem_arbiter
  import risc_toy_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int RD_LAT      = 1,
  parameter int D_MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_REQ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic              I_GNT,
  output logic              I_RVALID,
  output logic [DATA_W-1:0] I_RDATA,
  input  logic              D_REQ,
  input  logic              D_RW,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [DATA_W-1:0] D_RDATA,
  output logic              M_REQ,
  output logic              M_RW,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [DATA_W-1:0] M_WDATA,
  input  logic              M_READY,
  input  logic [DATA_W-1:0] M_RDATA
);

  localparam logic [3:0] BURST_LIM = 4'(D_MAX_BURST);

  arb_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cnt_next;
  logic        sel_d, sel_i;
  logic        i_gnt, d_gnt;
  logic        push_valid, push_src;
  logic        pipe_valid, pipe_src;
  logic        i_rvalid_q, i_rvalid_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  // Pick a requester; everything is gated off while reset is held.
  always_comb begin
    sel_d = 1'b0;
    sel_i = 1'b0;
    if (!RST) begin
      sel_d = D_REQ & (~I_REQ | (state_q == D_PRIO));
      sel_i = I_REQ & ~sel_d;
    end
  end

  // Drive the memory port from the selected requester; fetch never writes.
  always_comb begin
    M_REQ   = sel_d | sel_i;
    M_RW    = 1'b0;
    M_ADDR  = '0;
    M_WDATA = '0;
    if (sel_d) begin
      M_RW    = D_RW;
      M_ADDR  = D_ADDR;
      M_WDATA = D_WDATA;
    end else if (sel_i) begin
      M_ADDR  = I_ADDR;
    end
  end

  assign i_gnt = sel_i & M_READY;
  assign d_gnt = sel_d & M_READY;
  assign I_GNT = i_gnt;
  assign D_GNT = d_gnt;

  // Only accepted reads enter the tag pipe; writes complete on their grant.
  assign push_valid = i_gnt | (d_gnt & ~D_RW);
  assign push_src   = d_gnt ? SRC_D : SRC_I;

  // Next state and burst count; a stalled memory freezes both.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cnt_next = (cnt_q == BURST_LIM) ? cnt_q : cnt_q + 4'd1;
    if (M_READY && !RST) begin
      case (state_q)
        D_PRIO: begin
          if (i_gnt || !I_REQ) begin
            cnt_d = 4'd0;
          end else if (d_gnt) begin
            cnt_d = cnt_next;
            if (cnt_next == BURST_LIM) state_d = I_FORCE;
          end
        end
        I_FORCE: begin
          if (!I_REQ || i_gnt) begin
            state_d = D_PRIO;
            cnt_d   = 4'd0;
          end
        end
      endcase
    end
  end

  // Arbiter state and burst counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= D_PRIO;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  risc_toy_rtag_pipe #(
    .DEPTH(RD_LAT)
  ) u_rtag_pipe (
    .clk       (CLK),
    .clr       (RST),
    .push_valid(push_valid),
    .push_src  (push_src),
    .out_valid (pipe_valid),
    .out_src   (pipe_src)
  );

  // Steer returning memory data to the requester named by the oldest tag.
  always_comb begin
    i_rvalid_d = pipe_valid & (pipe_src == SRC_I);
    d_rvalid_d = pipe_valid & (pipe_src == SRC_D);
    i_rdata_d  = i_rvalid_d ? M_RDATA : i_rdata_q;
    d_rdata_d  = d_rvalid_d ? M_RDATA : d_rdata_q;
  end

  // Registered response outputs; data holds between valid pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign I_RVALID = i_rvalid_q;
  assign I_RDATA  = i_rdata_q;
  assign D_RVALID = d_rvalid_q;
  assign D_RDATA  = d_rdata_q;

endmodule

// File: tb/tb_risc_toy_mem_arbiter.sv
// Directed bench for risc_toy_mem_arbiter. Two instances share the same
// requester stimulus: one with RD_LAT=1, one with RD_LAT=3, both with
// D_MAX_BURST=4. Each has its own small behavioural memory.
module tb_risc_toy_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_rw, m_ready;
  logic [29:0] i_addr, d_addr;
  logic [31:0] d_wdata;

  logic        i_gnt1, i_rvalid1, d_gnt1, d_rvalid1, m_req1, m_rw1;
  logic [31:0] i_rdata1, d_rdata1, m_wdata1, m_rdata1;
  logic [29:0] m_addr1;
  logic        i_gnt3, i_rvalid3, d_gnt3, d_rvalid3, m_req3, m_rw3;
  logic [31:0] i_rdata3, d_rdata3, m_wdata3, m_rdata3;
  logic [29:0] m_addr3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  risc_toy_mem_arbiter #(.ADDR_W(30), .DATA_W(32), .RD_LAT(1), .D_MAX_BURST(4)) dut1 (
    .CLK(clk), .RST(rst),
    .I_REQ(i_req), .I_ADDR(i_addr), .I_GNT(i_gnt1), .I_RVALID(i_rvalid1), .I_RDATA(i_rdata1),
    .D_REQ(d_req), .D_RW(d_rw), .D_ADDR(d_addr), .D_WDATA(d_wdata),
    .D_GNT(d_gnt1), .D_RVALID(d_rvalid1), .D_RDATA(d_rdata1),
    .M_REQ(m_req1), .M_RW(m_rw1), .M_ADDR(m_addr1), .M_WDATA(m_wdata1),
    .M_READY(m_ready), .M_RDATA(m_rdata1)
  );

  risc_toy_mem_arbiter #(.ADDR_W(30), .DATA_W(32), .RD_LAT(3), .D_MAX_BURST(4)) dut3 (
    .CLK(clk), .RST(rst),
    .I_REQ(i_req), .I_ADDR(i_addr), .I_GNT(i_gnt3), .I_RVALID(i_rvalid3), .I_RDATA(i_rdata3),
    .D_REQ(d_req), .D_RW(d_rw), .D_ADDR(d_addr), .D_WDATA(d_wdata),
    .D_GNT(d_gnt3), .D_RVALID(d_rvalid3), .D_RDATA(d_rdata3),
    .M_REQ(m_req3), .M_RW(m_rw3), .M_ADDR(m_addr3), .M_WDATA(m_wdata3),
    .M_READY(m_ready), .M_RDATA(m_rdata3)
  );

  // Memory contents before any write: 0x10 holds DEADBEEF, others A5A5_<addr>.
  function automatic logic [31:0] dfltWord(input logic [29:0] a);
    if (a == 30'h10) return 32'hDEADBEEF;
    return {16'hA5A5, a[15:0]};
  endfunction

  logic [31:0]  mem1 [0:255];
  logic [31:0]  mem3 [0:255];
  logic [255:0] wv1 = '0;
  logic [255:0] wv3 = '0;
  logic [29:0]  mq1 [0:0];
  logic [29:0]  mq3 [0:2];

  // Memory models: remember read addresses for RD_LAT cycles, apply accepted writes.
  always @(posedge clk) begin
    mq1[0] <= m_addr1;
    mq3[0] <= m_addr3;
    mq3[1] <= mq3[0];
    mq3[2] <= mq3[1];
    if (m_req1 && m_ready && m_rw1) begin
      mem1[m_addr1[7:0]] <= m_wdata1;
      wv1[m_addr1[7:0]]  <= 1'b1;
    end
    if (m_req3 && m_ready && m_rw3) begin
      mem3[m_addr3[7:0]] <= m_wdata3;
      wv3[m_addr3[7:0]]  <= 1'b1;
    end
  end

  assign m_rdata1 = wv1[mq1[0][7:0]] ? mem1[mq1[0][7:0]] : dfltWord(mq1[0]);
  assign m_rdata3 = wv3[mq3[2][7:0]] ? mem3[mq3[2][7:0]] : dfltWord(mq3[2]);

  task automatic applyStimulus(input logic r, input logic ir, input logic [29:0] ia,
                               input logic dr, input logic drw, input logic [29:0] da,
                               input logic [31:0] dw, input logic mr);
    rst = r; i_req = ir; i_addr = ia; d_req = dr; d_rw = drw;
    d_addr = da; d_wdata = dw; m_ready = mr;
    #1;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, 30'h3F, 1'b0, 1'b0, 30'h3E, 32'h55, 1'b1);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held with both requests pending.
    applyStimulus(1'b1, 1'b1, 30'h40, 1'b1, 1'b0, 30'h44, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("rst_i_gnt", {31'b0, i_gnt1}, 32'd0);
      checkOutput("rst_d_gnt", {31'b0, d_gnt1}, 32'd0);
      checkOutput("rst_m_req", {31'b0, m_req1}, 32'd0);
      checkOutput("rst_i_rvalid", {31'b0, i_rvalid1}, 32'd0);
      checkOutput("rst_d_rvalid", {31'b0, d_rvalid1}, 32'd0);
      checkOutput("rst_d_rdata", d_rdata1, 32'd0);
    end

    // Starvation: both held high gives D,D,D,D,I,D,D,D,D,I.
    $display("[TB] burst limit sequence");
    for (int k = 0; k < 10; k++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b1, 30'h40, 1'b1, 1'b0, 30'h44, 32'h0, 1'b1);
      checkOutput($sformatf("burst_d_gnt1_%0d", k), {31'b0, d_gnt1}, (k == 4 || k == 9) ? 32'd0 : 32'd1);
      checkOutput($sformatf("burst_i_gnt1_%0d", k), {31'b0, i_gnt1}, (k == 4 || k == 9) ? 32'd1 : 32'd0);
      checkOutput($sformatf("burst_d_gnt3_%0d", k), {31'b0, d_gnt3}, (k == 4 || k == 9) ? 32'd0 : 32'd1);
      checkOutput($sformatf("burst_i_rvalid1_%0d", k), {31'b0, i_rvalid1}, (k == 6) ? 32'd1 : 32'd0);
      if (k == 0) checkOutput("burst_m_addr", {2'b0, m_addr1}, 32'h44);
      if (k == 6) checkOutput("burst_i_rdata", i_rdata1, 32'hA5A50040);
    end

    // Idle: memory port parked at zero.
    idleCycles(1);
    checkOutput("idle_m_req", {31'b0, m_req1}, 32'd0);
    checkOutput("idle_m_addr", {2'b0, m_addr1}, 32'd0);
    checkOutput("idle_m_wdata", m_wdata1, 32'd0);
    idleCycles(4);

    // Fetch only, RD_LAT=1: response two cycles after the grant.
    $display("[TB] fetch only");
    nextCycle();
    applyStimulus(1'b0, 1'b1, 30'h10, 1'b0, 1'b0, 30'h3E, 32'h0, 1'b1);
    checkOutput("fetch_i_gnt", {31'b0, i_gnt1}, 32'd1);
    checkOutput("fetch_d_gnt", {31'b0, d_gnt1}, 32'd0);
    checkOutput("fetch_m_addr", {2'b0, m_addr1}, 32'h10);
    checkOutput("fetch_m_rw", {31'b0, m_rw1}, 32'd0);
    idleCycles(1);
    checkOutput("fetch_rvalid_c1", {31'b0, i_rvalid1}, 32'd0);
    idleCycles(1);
    checkOutput("fetch_rvalid_c2", {31'b0, i_rvalid1}, 32'd1);
    checkOutput("fetch_rdata_c2", i_rdata1, 32'hDEADBEEF);
    checkOutput("fetch_d_rvalid_c2", {31'b0, d_rvalid1}, 32'd0);
    idleCycles(1);
    checkOutput("fetch_rvalid_c3", {31'b0, i_rvalid1}, 32'd0);
    checkOutput("fetch_rdata_hold", i_rdata1, 32'hDEADBEEF);
    idleCycles(3);

    // Interleaved reads: D 0x20 then I 0x24 in consecutive cycles.
    $display("[TB] interleaved reads");
    nextCycle();
    applyStimulus(1'b0, 1'b0, 30'h3F, 1'b1, 1'b0, 30'h20, 32'h0, 1'b1);
    checkOutput("inter_d_gnt3", {31'b0, d_gnt3}, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 30'h24, 1'b0, 1'b0, 30'h3E, 32'h0, 1'b1);
    checkOutput("inter_i_gnt3", {31'b0, i_gnt3}, 32'd1);
    idleCycles(1);
    checkOutput("inter_d_rvalid1_c2", {31'b0, d_rvalid1}, 32'd1);
    checkOutput("inter_d_rdata1_c2", d_rdata1, 32'hA5A50020);
    checkOutput("inter_d_rvalid3_c2", {31'b0, d_rvalid3}, 32'd0);
    idleCycles(1);
    checkOutput("inter_i_rvalid1_c3", {31'b0, i_rvalid1}, 32'd1);
    checkOutput("inter_i_rdata1_c3", i_rdata1, 32'hA5A50024);
    checkOutput("inter_d_rvalid3_c3", {31'b0, d_rvalid3}, 32'd0);
    checkOutput("inter_i_rvalid3_c3", {31'b0, i_rvalid3}, 32'd0);
    idleCycles(1);
    checkOutput("inter_d_rvalid3_c4", {31'b0, d_rvalid3}, 32'd1);
    checkOutput("inter_d_rdata3_c4", d_rdata3, 32'hA5A50020);
    checkOutput("inter_i_rvalid3_c4", {31'b0, i_rvalid3}, 32'd0);
    idleCycles(1);
    checkOutput("inter_i_rvalid3_c5", {31'b0, i_rvalid3}, 32'd1);
    checkOutput("inter_i_rdata3_c5", i_rdata3, 32'hA5A50024);
    checkOutput("inter_d_rvalid3_c5", {31'b0, d_rvalid3}, 32'd0);
    idleCycles(3);

    // Stall mid-burst: two data grants, five stalled cycles, then D,D,I.
    $display("[TB] memory stall");
    for (int s = 0; s < 2; s++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b1, 30'h40, 1'b1, 1'b0, 30'h44, 32'h0, 1'b1);
      checkOutput($sformatf("stall_pre_d_gnt_%0d", s), {31'b0, d_gnt1}, 32'd1);
    end
    for (int s = 0; s < 5; s++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b1, 30'h40, 1'b1, 1'b0, 30'h44, 32'h0, 1'b0);
      checkOutput($sformatf("stall_d_gnt_%0d", s), {31'b0, d_gnt1}, 32'd0);
      checkOutput($sformatf("stall_i_gnt_%0d", s), {31'b0, i_gnt1}, 32'd0);
      checkOutput($sformatf("stall_m_req_%0d", s), {31'b0, m_req1}, 32'd1);
    end
    for (int s = 0; s < 3; s++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b1, 30'h40, 1'b1, 1'b0, 30'h44, 32'h0, 1'b1);
      checkOutput($sformatf("stall_post_d_gnt_%0d", s), {31'b0, d_gnt1}, (s == 2) ? 32'd0 : 32'd1);
      checkOutput($sformatf("stall_post_i_gnt_%0d", s), {31'b0, i_gnt1}, (s == 2) ? 32'd1 : 32'd0);
    end
    idleCycles(5);

    // Write 0x30, confirm no response, then read it back.
    $display("[TB] write and flush");
    nextCycle();
    applyStimulus(1'b0, 1'b0, 30'h3F, 1'b1, 1'b1, 30'h30, 32'h12345678, 1'b1);
    checkOutput("wr_d_gnt", {31'b0, d_gnt1}, 32'd1);
    checkOutput("wr_m_rw", {31'b0, m_rw1}, 32'd1);
    checkOutput("wr_m_addr", {2'b0, m_addr1}, 32'h30);
    checkOutput("wr_m_wdata", m_wdata1, 32'h12345678);
    for (int w = 0; w < 4; w++) begin
      idleCycles(1);
      checkOutput($sformatf("wr_d_rvalid1_%0d", w), {31'b0, d_rvalid1}, 32'd0);
      checkOutput($sformatf("wr_d_rvalid3_%0d", w), {31'b0, d_rvalid3}, 32'd0);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 30'h3F, 1'b1, 1'b0, 30'h30, 32'h0, 1'b1);
    checkOutput("rb_d_gnt", {31'b0, d_gnt1}, 32'd1);
    checkOutput("rb_m_rw", {31'b0, m_rw1}, 32'd0);
    idleCycles(2);
    checkOutput("rb_d_rvalid", {31'b0, d_rvalid1}, 32'd1);
    checkOutput("rb_d_rdata", d_rdata1, 32'h12345678);
    idleCycles(3);

    // Read granted, then reset one cycle later: the read must vanish.
    nextCycle();
    applyStimulus(1'b0, 1'b0, 30'h3F, 1'b1, 1'b0, 30'h30, 32'h0, 1'b1);
    checkOutput("flush_d_gnt1", {31'b0, d_gnt1}, 32'd1);
    checkOutput("flush_d_gnt3", {31'b0, d_gnt3}, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 30'h40, 1'b1, 1'b0, 30'h30, 32'h0, 1'b1);
    checkOutput("flush_rst_m_req", {31'b0, m_req1}, 32'd0);
    checkOutput("flush_rst_d_gnt", {31'b0, d_gnt1}, 32'd0);
    checkOutput("flush_rst_i_gnt", {31'b0, i_gnt1}, 32'd0);
    for (int f = 0; f < 6; f++) begin
      idleCycles(1);
      checkOutput($sformatf("flush_d_rvalid1_%0d", f), {31'b0, d_rvalid1}, 32'd0);
      checkOutput($sformatf("flush_d_rvalid3_%0d", f), {31'b0, d_rvalid3}, 32'd0);
      checkOutput($sformatf("flush_i_rvalid1_%0d", f), {31'b0, i_rvalid1}, 32'd0);
      checkOutput($sformatf("flush_i_rvalid3_%0d", f), {31'b0, i_rvalid3}, 32'd0);
      if (f == 0) begin
        checkOutput("flush_d_rdata1_cleared", d_rdata1, 32'd0);
        checkOutput("flush_d_rdata3_cleared", d_rdata3, 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
